// File: rtl/muldiv_unit_v2.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and divide-by-zero / overflow handling.
module muldiv_unit_v2 #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [7:0]       muldiv_error_vector
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic               sign_a_reg;
    logic               neg_reg;
    logic               dz_reg;
    logic               ovf_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]   result_lo_reg;
    logic [WIDTH-1:0]   result_hi_reg;
    logic [2:0]         err_reg;

    logic accept;
    assign accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    // Decode of the latched op and operands; meaningful from PREP onward.
    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic             sgn_ovf;
    logic             sel_hi;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] early_lo;
    logic [WIDTH-1:0] early_hi;

    always_comb begin
        is_div   = op_reg[2];
        a_signed = (op_reg == OP_MULH) || (op_reg == OP_MULHSU) ||
                   (op_reg == OP_DIV)  || (op_reg == OP_REM);
        b_signed = (op_reg == OP_MULH) || (op_reg == OP_DIV) || (op_reg == OP_REM);
        sign_a   = a_signed && a_reg[WIDTH-1];
        sign_b   = b_signed && b_reg[WIDTH-1];
        mag_a    = sign_a ? ('0 - a_reg) : a_reg;
        mag_b    = sign_b ? ('0 - b_reg) : b_reg;
        div_zero = is_div && (b_reg == '0);
        sgn_ovf  = is_div && !op_reg[0] && (a_reg == MIN_NEG) && (b_reg == '1);
        sel_hi   = !((op_reg == OP_MUL) || (op_reg == OP_DIV) || (op_reg == OP_DIVU));
        early_lo = div_zero ? '1 : a_reg;
        early_hi = div_zero ? a_reg : '0;
    end

    // One iteration step. For divide, acc holds {remainder, dividend/quotient}.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, m_reg} : '0);
        mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
        div_part  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_trial = div_part - {1'b0, m_reg};
        if (!div_trial[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_part[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end
    end

    // Sign restoration; the special cases override the raw iteration results.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   fix_hi;

    always_comb begin
        prod_fix = neg_reg ? ('0 - acc_reg) : acc_reg;
        quo_fix  = neg_reg ? ('0 - acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0];
        rem_fix  = sign_a_reg ? ('0 - acc_reg[2*WIDTH-1:WIDTH]) : acc_reg[2*WIDTH-1:WIDTH];
        if (dz_reg) begin
            quo_fix = '1;
            rem_fix = a_reg;
        end else if (ovf_reg) begin
            quo_fix = a_reg;
            rem_fix = '0;
        end
        fix_lo = is_div ? quo_fix : prod_fix[WIDTH-1:0];
        fix_hi = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            m_reg         <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sign_a_reg    <= 1'b0;
            neg_reg       <= 1'b0;
            dz_reg        <= 1'b0;
            ovf_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= '0;
            result_lo_reg <= '0;
            result_hi_reg <= '0;
            err_reg       <= '0;
        end else begin
            case (state_reg)
                S_PREP: begin
                    sign_a_reg <= sign_a;
                    neg_reg    <= sign_a ^ sign_b;
                    dz_reg     <= div_zero;
                    ovf_reg    <= sgn_ovf;
                    m_reg      <= is_div ? mag_b : mag_a;
                    acc_reg    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    cnt_reg    <= CW'(WIDTH - 1);
                    if (EARLY_OUT && (div_zero || sgn_ovf)) begin
                        result_lo_reg <= early_lo;
                        result_hi_reg <= early_hi;
                        result_reg    <= sel_hi ? early_hi : early_lo;
                        err_reg[0]    <= err_reg[0] | div_zero;
                        err_reg[1]    <= err_reg[1] | sgn_ovf;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= S_DONE;
                    end else begin
                        state_reg <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_reg <= is_div ? div_next : mul_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_lo_reg <= fix_lo;
                    result_hi_reg <= fix_hi;
                    result_reg    <= sel_hi ? fix_hi : fix_lo;
                    err_reg[0]    <= err_reg[0] | dz_reg;
                    err_reg[1]    <= err_reg[1] | ovf_reg;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b1;
                    state_reg     <= S_DONE;
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase

            // Acceptance overrides the DONE -> IDLE return for back-to-back ops.
            if (accept) begin
                op_reg    <= op;
                a_reg     <= operand_a;
                b_reg     <= operand_b;
                err_reg   <= '0;
                busy_reg  <= 1'b1;
                state_reg <= S_PREP;
            end
            if (start && busy_reg) begin
                err_reg[2] <= 1'b1;
            end
        end
    end

    assign busy                = busy_reg;
    assign done                = done_reg;
    assign result              = result_reg;
    assign result_lo           = result_lo_reg;
    assign result_hi           = result_hi_reg;
    assign muldiv_error_vector = {5'b0, err_reg};

endmodule

// File: tb/tb_muldiv_unit_v2.sv
// Bench for muldiv_unit_v2: a fixed-latency instance and an EARLY_OUT instance,
// checked against an arithmetic reference model plus literal expectations.
module tb_muldiv_unit_v2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;

    logic        busy0, done0, busy1, done1;
    logic [31:0] res0, lo0, hi0, res1, lo1, hi1;
    logic [7:0]  err0, err1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction tracking, written only by the driver.
    logic        track = 1'b0;
    logic        track_sel = 1'b0;
    int          acc_cyc = 0;
    int          exp_lat = 0;
    logic [2:0]  t_op = 3'd0;
    logic [31:0] t_a = 32'd0, t_b = 32'd0, t_lo = 32'd0, t_hi = 32'd0, t_res = 32'd0;
    logic [7:0]  t_err = 8'd0, exp_err_or = 8'd0;

    // One-off probes: mask bits [5]busy [4]done [3]result [2]lo [1]hi [0]err.
    logic        probe_req = 1'b0;
    logic        probe_sel = 1'b0;
    logic [5:0]  probe_mask = 6'd0;
    string       probe_name = "";
    logic        p_busy = 1'b0, p_done = 1'b0;
    logic [31:0] p_res = 32'd0, p_lo = 32'd0, p_hi = 32'd0;
    logic [7:0]  p_err = 8'd0;

    muldiv_unit_v2 #(.WIDTH(32), .EARLY_OUT(1'b0)) u_fixed (
        .clk(clk), .rst(rst), .start(start0), .op(op_i),
        .operand_a(a_i), .operand_b(b_i),
        .busy(busy0), .done(done0), .result(res0), .result_lo(lo0), .result_hi(hi0),
        .muldiv_error_vector(err0)
    );

    muldiv_unit_v2 #(.WIDTH(32), .EARLY_OUT(1'b1)) u_early (
        .clk(clk), .rst(rst), .start(start1), .op(op_i),
        .operand_a(a_i), .operand_b(b_i),
        .busy(busy1), .done(done1), .result(res1), .result_lo(lo1), .result_hi(hi1),
        .muldiv_error_vector(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain 64-bit arithmetic on the RV32M definitions.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic [31:0] res, output logic [7:0] err);
        longint      pa, pb;
        logic [63:0] p;
        err = 8'd0;
        lo  = 32'd0;
        hi  = 32'd0;
        if (!o[2]) begin
            pa = (o == 3'd1 || o == 3'd2) ? longint'($signed(a)) : longint'(a);
            pb = (o == 3'd1) ? longint'($signed(b)) : longint'(b);
            p  = 64'(pa * pb);
            lo = p[31:0];
            hi = p[63:32];
        end else if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
            err[0] = 1'b1;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = a;
            hi = 32'd0;
            err[1] = 1'b1;
        end else if (!o[0]) begin
            lo = 32'($signed(a) / $signed(b));
            hi = 32'($signed(a) % $signed(b));
        end else begin
            lo = a / b;
            hi = a % b;
        end
        res = (o == 3'd0 || o == 3'd4 || o == 3'd5) ? lo : hi;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h (t=%0t)", nm, fld, act, exp, $time);
        end
    endtask

    // The single compare process: per-cycle busy/done, results at done, and probes.
    initial begin : compare
        int          n;
        logic        ob, od;
        logic [31:0] ores, olo, ohi;
        logic [7:0]  oerr;
        forever begin
            @(negedge clk);
            if (track) begin
                ob   = track_sel ? busy1 : busy0;
                od   = track_sel ? done1 : done0;
                ores = track_sel ? res1 : res0;
                olo  = track_sel ? lo1 : lo0;
                ohi  = track_sel ? hi1 : hi0;
                oerr = track_sel ? err1 : err0;
                n = cyc - acc_cyc + 1;
                if (n <= exp_lat) begin
                    chk("txn", "busy", 32'(ob), 32'(n < exp_lat));
                    chk("txn", "done", 32'(od), 32'(n == exp_lat));
                    if (n == exp_lat) begin
                        chk("txn", "result", ores, t_res);
                        chk("txn", "result_lo", olo, t_lo);
                        chk("txn", "result_hi", ohi, t_hi);
                        chk("txn", "error", 32'(oerr), 32'(t_err | exp_err_or));
                        $display("txn dut%0d op=%0d a=%h b=%h result=%h lo=%h hi=%h err=%h cycle=%0d",
                                 track_sel, t_op, t_a, t_b, ores, olo, ohi, oerr, n);
                    end
                end
            end
            if (probe_req) begin
                ob   = probe_sel ? busy1 : busy0;
                od   = probe_sel ? done1 : done0;
                ores = probe_sel ? res1 : res0;
                olo  = probe_sel ? lo1 : lo0;
                ohi  = probe_sel ? hi1 : hi0;
                oerr = probe_sel ? err1 : err0;
                if (probe_mask[5]) chk(probe_name, "busy", 32'(ob), 32'(p_busy));
                if (probe_mask[4]) chk(probe_name, "done", 32'(od), 32'(p_done));
                if (probe_mask[3]) chk(probe_name, "result", ores, p_res);
                if (probe_mask[2]) chk(probe_name, "result_lo", olo, p_lo);
                if (probe_mask[1]) chk(probe_name, "result_hi", ohi, p_hi);
                if (probe_mask[0]) chk(probe_name, "error", 32'(oerr), 32'(p_err));
            end
        end
    end

    task automatic probe(input logic sel, input string nm, input logic [5:0] m,
                         input logic eb, input logic ed, input logic [31:0] er,
                         input logic [31:0] el, input logic [31:0] eh, input logic [7:0] ee);
        probe_sel = sel; probe_name = nm; probe_mask = m;
        p_busy = eb; p_done = ed; p_res = er; p_lo = el; p_hi = eh; p_err = ee;
        probe_req = 1'b1;
        @(negedge clk);
        #1;
        probe_req = 1'b0;
    endtask

    // Drive start for one edge, then scramble inputs to show they were latched.
    task automatic issue(input logic sel, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat);
        op_i = o; a_i = a; b_i = b;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0; start1 = 1'b0;
        op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
        track_sel = sel; t_op = o; t_a = a; t_b = b;
        model(o, a, b, t_lo, t_hi, t_res, t_err);
        exp_err_or = 8'd0;
        acc_cyc = cyc;
        exp_lat = lat;
        track = 1'b1;
    endtask

    // Returns #1 after the edge that raises done, or flags a timeout.
    task automatic wait_done(input logic sel);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!(sel ? done1 : done0) && k < 100);
        if (!(sel ? done1 : done0)) begin
            probe(sel, "done_timeout", 6'b010000, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 8'd0);
        end
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[12];

    initial begin : driver
        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFB, 32'h0000_0003};
        vecs[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000};
        vecs[3]  = '{3'd3, 32'h1234_5678, 32'h9ABC_DEF0};
        vecs[4]  = '{3'd5, 32'd100, 32'd7};
        vecs[5]  = '{3'd7, 32'd100, 32'd7};
        vecs[6]  = '{3'd6, 32'd7, 32'hFFFF_FFFE};
        vecs[7]  = '{3'd4, 32'h8000_0000, 32'd2};
        vecs[8]  = '{3'd4, 32'hFFFF_FFF9, 32'd0};
        vecs[9]  = '{3'd6, 32'hFFFF_FFF9, 32'd0};
        vecs[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[11] = '{3'd2, 32'h8000_0001, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        probe(1'b0, "in_reset", 6'h3F, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        probe(1'b0, "after_reset", 6'h3F, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0);
        probe(1'b1, "after_reset_eo", 6'h3F, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0);

        // T1 .. T3 with literal expectations
        issue(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        wait_done(1'b0);
        probe(1'b0, "T1_mulhu", 6'b001111, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE, 8'd0);
        issue(1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 35);
        wait_done(1'b0);
        probe(1'b0, "T2_mulhsu", 6'b001110, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 8'd0);
        issue(1'b0, 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 35);
        wait_done(1'b0);
        probe(1'b0, "T3_div", 6'b001000, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd0, 32'd0, 8'd0);
        issue(1'b0, 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 35);
        wait_done(1'b0);
        probe(1'b0, "T3_rem", 6'b001000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 8'd0);

        for (int i = 0; i < 12; i++) begin
            issue(1'b0, vecs[i].o, vecs[i].a, vecs[i].b, 35);
            wait_done(1'b0);
        end

        // T4 divide by zero, T5 signed overflow, then error clear on next start
        issue(1'b0, 3'd5, 32'h0000_1234, 32'd0, 35);
        wait_done(1'b0);
        probe(1'b0, "T4_divu0", 6'b001011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h0000_1234, 8'h01);
        issue(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 35);
        wait_done(1'b0);
        probe(1'b0, "T5_ovf", 6'b001011, 1'b0, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 8'h02);
        issue(1'b0, 3'd0, 32'd3, 32'd5, 35);
        probe(1'b0, "T5_clear", 6'b000001, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 8'h00);
        wait_done(1'b0);

        // T6 start while busy is ignored and flagged
        issue(1'b0, 3'd4, 32'd1000, 32'd7, 35);
        repeat (8) @(posedge clk);
        #1;
        op_i = 3'd0; a_i = 32'd9; b_i = 32'd9; start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        exp_err_or = 8'h04;
        probe(1'b0, "T6_busy_start", 6'b000001, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 8'h04);
        wait_done(1'b0);

        // T6 reset mid-operation
        issue(1'b0, 3'd3, 32'hDEAD_BEEF, 32'h1357_9BDF, 35);
        repeat (19) @(posedge clk);
        #1;
        track = 1'b0;
        rst = 1'b0;
        #1;
        probe(1'b0, "T6_abort", 6'h3F, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        probe_sel = 1'b0; probe_name = "T6_no_done"; probe_mask = 6'b110000;
        p_busy = 1'b0; p_done = 1'b0;
        probe_req = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        probe_req = 1'b0;

        // T6 back-to-back starts in the DONE cycle
        issue(1'b0, 3'd5, 32'hFFFF_0000, 32'd13, 35);
        wait_done(1'b0);
        issue(1'b0, 3'd7, 32'hFFFF_0000, 32'd13, 35);
        wait_done(1'b0);
        issue(1'b0, 3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 35);
        wait_done(1'b0);

        // EARLY_OUT instance
        issue(1'b1, 3'd5, 32'h0000_1234, 32'd0, 2);
        wait_done(1'b1);
        probe(1'b1, "T4_early", 6'b001011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h0000_1234, 8'h01);
        issue(1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2);
        wait_done(1'b1);
        issue(1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2, 35);
        wait_done(1'b1);
        issue(1'b1, 3'd7, 32'h0000_0055, 32'd0, 2);
        wait_done(1'b1);
        issue(1'b1, 3'd0, 32'h0001_0001, 32'h0001_0001, 35);
        wait_done(1'b1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
